// File: rtl/match_judge.sv
// Rock-paper-scissors round resolver: latches the player move, draws a CPU move
// from a free-running LFSR (or a forced value), and emits a one-cycle result code.
module match_judge #(
  parameter int          MAX_ROUNDS = 9,
  parameter logic [7:0]  LFSR_SEED  = 8'hA5
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       move_valid,
  input  logic [1:0] player_move,
  input  logic [1:0] cpu_force,
  output logic [1:0] matchresult,
  output logic [1:0] cpu_move,
  output logic [3:0] rounds_played,
  output logic       busy,
  output logic       game_over
);

  // state    | meaning
  // IDLE     | waiting for a valid player move
  // DRAW     | picking a nonzero CPU move, retrying on 00
  // EMIT     | result pulse visible for this cycle
  // WAIT_REL | waiting for the button to be released
  // DONE     | game finished, only reset leaves
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] DRAW     = 3'd1;
  localparam logic [2:0] EMIT     = 3'd2;
  localparam logic [2:0] WAIT_REL = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [7:0] SEED_EFF = (LFSR_SEED == 8'h00) ? 8'h01 : LFSR_SEED;
  localparam logic [3:0] MAX_R    = 4'(MAX_ROUNDS);

  logic [2:0] state_q, state_d;
  logic [7:0] lfsr_q, lfsr_d;
  logic [1:0] player_q, player_d;
  logic [1:0] result_q, result_d;
  logic [1:0] cpu_q, cpu_d;
  logic [3:0] rounds_q, rounds_d;
  logic       busy_q, busy_d;
  logic       over_q, over_d;
  logic [1:0] cand;

  function automatic logic [1:0] judge(input logic [1:0] p, input logic [1:0] c);
    if (p == c) begin
      judge = 2'b01;
    end else if ((p == 2'b01 && c == 2'b11) ||
                 (p == 2'b10 && c == 2'b01) ||
                 (p == 2'b11 && c == 2'b10)) begin
      judge = 2'b10;
    end else begin
      judge = 2'b11;
    end
  endfunction

  assign cand = (cpu_force != 2'b00) ? cpu_force : lfsr_q[1:0];

  always_comb begin
    state_d  = state_q;
    player_d = player_q;
    result_d = result_q;
    cpu_d    = cpu_q;
    rounds_d = rounds_q;
    // Taps 8,6,5,4; a nonzero seed can never shift into the all-zero state.
    lfsr_d   = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    case (state_q)
      IDLE: begin
        if (move_valid && player_move != 2'b00) begin
          player_d = player_move;
          state_d  = DRAW;
        end
      end
      DRAW: begin
        if (cand != 2'b00) begin
          cpu_d    = cand;
          result_d = judge(player_q, cand);
          rounds_d = rounds_q + 4'd1;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        result_d = 2'b00;
        state_d  = (rounds_q == MAX_R) ? DONE : WAIT_REL;
      end
      WAIT_REL: begin
        if (!move_valid) state_d = IDLE;
      end
      DONE: begin
        state_d = DONE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
    busy_d = (state_d != IDLE) && (state_d != DONE);
    over_d = (state_d == DONE);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      lfsr_q   <= SEED_EFF;
      player_q <= 2'b00;
      result_q <= 2'b00;
      cpu_q    <= 2'b00;
      rounds_q <= 4'd0;
      busy_q   <= 1'b0;
      over_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      lfsr_q   <= lfsr_d;
      player_q <= player_d;
      result_q <= result_d;
      cpu_q    <= cpu_d;
      rounds_q <= rounds_d;
      busy_q   <= busy_d;
      over_q   <= over_d;
    end
  end

  assign matchresult   = result_q;
  assign cpu_move      = cpu_q;
  assign rounds_played = rounds_q;
  assign busy          = busy_q;
  assign game_over     = over_q;

endmodule

// File: tb/tb_match_judge.sv
// Bench for match_judge: judge table vectors, a result scoreboard with timing,
// a reference LFSR for unforced rounds, and reset/hold/DONE corner sequences.
module tb_match_judge;

  typedef struct {
    logic [1:0] p;
    logic [1:0] f;
    logic [1:0] res;
  } vec_t;

  typedef struct {
    logic [1:0] res;
    logic [1:0] cpu;
    logic [3:0] rnd;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       resetn;
  logic       move_valid;
  logic [1:0] player_move;
  logic [1:0] cpu_force;
  logic [1:0] matchresult, cpu_move;
  logic [3:0] rounds_played;
  logic       busy, game_over;
  logic [1:0] matchresult2, cpu_move2;
  logic [3:0] rounds_played2;
  logic       busy2, game_over2;

  int   n_cmp = 0;
  int   n_err = 0;
  int   cyc = 0;
  int   p2_cnt = 0;
  int   p2_base;
  int   exp_rounds = 0;
  bit   prev_nz = 0;
  logic [7:0] m_lfsr;
  vec_t vec [9];
  exp_t sb [$];

  match_judge #(.MAX_ROUNDS(9), .LFSR_SEED(8'hA5)) u_dut (
    .clk(clk), .resetn(resetn), .move_valid(move_valid), .player_move(player_move),
    .cpu_force(cpu_force), .matchresult(matchresult), .cpu_move(cpu_move),
    .rounds_played(rounds_played), .busy(busy), .game_over(game_over));

  match_judge #(.MAX_ROUNDS(2), .LFSR_SEED(8'hA5)) u_dut2 (
    .clk(clk), .resetn(resetn), .move_valid(move_valid), .player_move(player_move),
    .cpu_force(cpu_force), .matchresult(matchresult2), .cpu_move(cpu_move2),
    .rounds_played(rounds_played2), .busy(busy2), .game_over(game_over2));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] lfsr_next(input logic [7:0] l);
    return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
  endfunction

  always @(posedge clk or negedge resetn) begin
    if (!resetn) m_lfsr <= 8'hA5;
    else         m_lfsr <= lfsr_next(m_lfsr);
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [1:0] judge_ref(input logic [1:0] p, input logic [1:0] c);
    logic [1:0] r = 2'b00;
    foreach (vec[i]) if (vec[i].p == p && vec[i].f == c) r = vec[i].res;
    return r;
  endfunction

  // Result monitor: every nonzero pulse must match the oldest expected round.
  always @(negedge clk) begin
    if (resetn) begin
      if (matchresult2 != 2'b00) p2_cnt <= p2_cnt + 1;
      if (matchresult != 2'b00) begin
        if (prev_nz) chk("pulse_width_cycles", 2, 1);
        if (sb.size() == 0) begin
          chk("unexpected_pulse", int'(matchresult), 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sb_result", int'(matchresult), int'(e.res));
          chk("sb_cpu_move", int'(cpu_move), int'(e.cpu));
          chk("sb_rounds", int'(rounds_played), int'(e.rnd));
          chk("sb_pulse_cycle", cyc, e.cyc);
        end
      end
      prev_nz <= (matchresult != 2'b00);
    end else begin
      prev_nz <= 1'b0;
    end
  end

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    move_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    exp_rounds = 0;
    sb.delete();
  endtask

  task automatic wait_sb();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      chk("sb_timeout_pending", sb.size(), 0);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  // Called at a negedge with the DUT idle; pushes the expected round, then presses.
  task automatic play(input logic [1:0] p, input logic [1:0] f);
    exp_t e;
    logic [7:0] l;
    int skips = 0;
    if (f != 2'b00) begin
      e.cpu = f;
    end else begin
      l = lfsr_next(m_lfsr);
      while (l[1:0] == 2'b00) begin
        l = lfsr_next(l);
        skips++;
      end
      e.cpu = l[1:0];
    end
    exp_rounds++;
    e.res = judge_ref(p, e.cpu);
    e.rnd = 4'(exp_rounds);
    e.cyc = cyc + 2 + skips;
    sb.push_back(e);
    move_valid  = 1'b1;
    player_move = p;
    cpu_force   = f;
    @(negedge clk);
    move_valid  = 1'b0;
    player_move = 2'($urandom_range(0, 3));
    wait_sb();
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    vec[0] = '{2'b01, 2'b01, 2'b01};
    vec[1] = '{2'b01, 2'b10, 2'b11};
    vec[2] = '{2'b01, 2'b11, 2'b10};
    vec[3] = '{2'b10, 2'b01, 2'b10};
    vec[4] = '{2'b10, 2'b10, 2'b01};
    vec[5] = '{2'b10, 2'b11, 2'b11};
    vec[6] = '{2'b11, 2'b01, 2'b11};
    vec[7] = '{2'b11, 2'b10, 2'b10};
    vec[8] = '{2'b11, 2'b11, 2'b01};
    resetn = 1'b0;
    move_valid = 1'b0;
    player_move = 2'b00;
    cpu_force = 2'b00;
    #12;
    chk("rst_matchresult", int'(matchresult), 0);
    chk("rst_cpu_move", int'(cpu_move), 0);
    chk("rst_rounds", int'(rounds_played), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_game_over", int'(game_over), 0);
    do_reset();

    // First round: rock vs forced scissors, with busy timing.
    sb.push_back('{2'b10, 2'b11, 4'd1, cyc + 2});
    exp_rounds = 1;
    move_valid = 1'b1; player_move = 2'b01; cpu_force = 2'b11;
    @(posedge clk); #1;
    chk("busy_after_accept", int'(busy), 1);
    @(negedge clk);
    move_valid = 1'b0;
    wait_sb();
    chk("r1_cpu_move_held", int'(cpu_move), 3);
    chk("r1_rounds", int'(rounds_played), 1);
    chk("r1_busy_idle", int'(busy), 0);
    chk("r1_matchresult_cleared", int'(matchresult), 0);

    // Whole judge table; game ends after the ninth round.
    do_reset();
    p2_base = p2_cnt;
    foreach (vec[i]) begin
      play(vec[i].p, vec[i].f);
      chk("table_rounds", int'(rounds_played), i + 1);
    end
    chk("table_game_over", int'(game_over), 1);
    chk("table_busy_done", int'(busy), 0);
    chk("done2_pulses", p2_cnt - p2_base, 2);
    chk("done2_cpu_move", int'(cpu_move2), 2);
    for (int k = 0; k < 3; k++) begin
      move_valid = 1'b1; player_move = 2'(k + 1); cpu_force = 2'b01;
      repeat (2) @(negedge clk);
      move_valid = 1'b0;
      repeat (3) @(negedge clk);
    end
    chk("done_rounds_hold", int'(rounds_played), 9);
    chk("done_game_over_hold", int'(game_over), 1);
    chk("done2_rounds_hold", int'(rounds_played2), 2);
    chk("done2_game_over_hold", int'(game_over2), 1);
    chk("done2_busy", int'(busy2), 0);
    chk("done2_no_more_pulses", p2_cnt - p2_base, 2);

    // Held button: exactly one round until release.
    do_reset();
    exp_rounds = 1;
    sb.push_back('{2'b10, 2'b01, 4'd1, cyc + 2});
    move_valid = 1'b1; player_move = 2'b10; cpu_force = 2'b01;
    repeat (20) @(negedge clk);
    chk("hold_rounds", int'(rounds_played), 1);
    chk("hold_busy_wait_rel", int'(busy), 1);
    move_valid = 1'b0;
    wait_sb();
    play(2'b10, 2'b01);
    chk("hold_second_rounds", int'(rounds_played), 2);

    // Unforced rounds against the reference LFSR, with random idle gaps.
    do_reset();
    for (int i = 0; i < 8; i++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      play(2'((i % 3) + 1), 2'b00);
    end
    chk("lfsr_rounds", int'(rounds_played), 8);

    // Reset while a lose pulse is live.
    do_reset();
    move_valid = 1'b1; player_move = 2'b01; cpu_force = 2'b10;
    @(negedge clk);
    move_valid = 1'b0;
    @(posedge clk); #2;
    chk("emit_matchresult_live", int'(matchresult), 3);
    chk("emit_rounds_live", int'(rounds_played), 1);
    resetn = 1'b0;
    #1;
    chk("emit_rst_matchresult", int'(matchresult), 0);
    chk("emit_rst_rounds", int'(rounds_played), 0);
    chk("emit_rst_busy", int'(busy), 0);
    @(negedge clk);
    resetn = 1'b1;
    exp_rounds = 0;
    @(negedge clk);
    play(2'b10, 2'b01);
    chk("post_rst_rounds", int'(rounds_played), 1);
    chk("post_rst_game_over", int'(game_over), 0);

    chk("sb_empty_at_end", sb.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
